// File: rtl/line_route_loader_if.sv
// rtl/line_route_loader_if.sv - register port and select bus of the line route loader
interface line_route_loader_if #(
  parameter int NUM_INPUTS  = 10,
  parameter int NUM_OUTPUTS = 10
);
  localparam int AW = $clog2(NUM_OUTPUTS);
  localparam int DW = $clog2(NUM_INPUTS + 2);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_err;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          commit;
  logic          busy;
  logic          done;
  logic [DW-1:0] input_select;
  logic [AW-1:0] output_select;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, commit,
    input  wr_err, rd_data, busy, done, input_select, output_select
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, commit,
    output wr_err, rd_data, busy, done, input_select, output_select
  );
endinterface

// File: rtl/line_route_loader.sv
// rtl/line_route_loader.sv - shadow routing table swept onto the line_mux select bus
module line_route_loader #(
  parameter int NUM_INPUTS  = 10,
  parameter int NUM_OUTPUTS = 10
) (
  input  logic                clk,
  input  logic                rstn,
  line_route_loader_if.slave  bus
);
  localparam int AW = $clog2(NUM_OUTPUTS);
  localparam int DW = $clog2(NUM_INPUTS + 2);

  localparam logic [AW:0]   NUM_OUT_W = (AW+1)'(NUM_OUTPUTS);
  localparam logic [DW:0]   MAX_CODE  = (DW+1)'(NUM_INPUTS + 1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_OUTPUTS - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] shadow [NUM_OUTPUTS];
  logic [AW-1:0] idx;
  logic          pending;
  logic [DW-1:0] park_in;
  logic [AW-1:0] park_out;
  logic          wr_ok;
  logic          rd_in_range;

  // The table must not move while it is being streamed, so writes are only taken outside SWEEP.
  assign wr_ok = bus.wr_en && (state != SWEEP)
              && ({1'b0, bus.wr_addr} < NUM_OUT_W)
              && ({1'b0, bus.wr_data} <= MAX_CODE);

  assign rd_in_range = ({1'b0, bus.rd_addr} < NUM_OUT_W);

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: a commit arriving in DONE is folded into the pending re-sweep.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.commit) state_nxt = SWEEP;
      SWEEP:   if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = (pending || bus.commit) ? SWEEP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: stream shadow[idx] while sweeping, otherwise hold the last driven pair.
  always_comb begin
    bus.busy          = (state == SWEEP);
    bus.done          = (state == DONE);
    bus.output_select = park_out;
    bus.input_select  = park_in;
    if (state == SWEEP) begin
      bus.output_select = idx;
      bus.input_select  = shadow[idx];
    end
  end

  // Shadow table writes and the one-cycle rejection pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) shadow[i] <= '0;
      bus.wr_err <= 1'b0;
    end else begin
      if (wr_ok) shadow[bus.wr_addr] <= bus.wr_data;
      bus.wr_err <= bus.wr_en && !wr_ok;
    end
  end

  // Registered readback; out-of-range indices read as zero.
  always_ff @(posedge clk) begin
    if (!rstn)            bus.rd_data <= '0;
    else if (rd_in_range) bus.rd_data <= shadow[bus.rd_addr];
    else                  bus.rd_data <= '0;
  end

  // Sweep index, parked select pair and collapsed re-sweep request.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx      <= '0;
      pending  <= 1'b0;
      park_in  <= '0;
      park_out <= '0;
    end else begin
      idx <= (state == SWEEP && idx != LAST_IDX) ? idx + 1'b1 : '0;
      if (state == SWEEP) begin
        park_out <= idx;
        park_in  <= shadow[idx];
        if (bus.commit) pending <= 1'b1;
      end else if (state == DONE) begin
        pending <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_line_route_loader.sv
// tb/tb_line_route_loader.sv - randomized self-checking bench for line_route_loader
module tb_line_route_loader;
  localparam int NI = 10;
  localparam int NO = 10;
  localparam int AW = $clog2(NO);
  localparam int DW = $clog2(NI + 2);

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  line_route_loader_if #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO)) bus ();

  line_route_loader #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int model [NO];
  int park_in, park_out;
  int mux_sel [NO];
  logic [NI-1:0] in_vec;

  // Ten line_mux stand-ins: each holds the code present while its ID is selected.
  always @(negedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NO; i++) mux_sel[i] <= 0;
    end else if (int'(bus.output_select) < NO) begin
      mux_sel[bus.output_select] <= int'(bus.input_select);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int route(input int code, input logic [NI-1:0] v);
    if (code == 0) return 0;
    if (code == 1) return 1;
    return int'(v[code-2]);
  endfunction

  task automatic do_write(input int addr, input int data);
    bit ok;
    ok = (addr < NO) && (data <= NI + 1);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr[AW-1:0];
    bus.wr_data = data[DW-1:0];
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    if (ok) model[addr] = data;
    @(negedge clk);
    check("wr_err", bus.wr_err, ok ? 0 : 1);
    check("park_isel", bus.input_select, park_in);
    check("park_osel", bus.output_select, park_out);
  endtask

  task automatic do_read(input int addr);
    bus.rd_addr = addr[AW-1:0];
    @(posedge clk);
    @(negedge clk);
    check("rd_data", bus.rd_data, (addr < NO) ? model[addr] : 0);
  endtask

  // Caller raises commit at a negedge; this follows the resulting sweep(s) cycle by cycle.
  task automatic run_sweep(input int n_commits, input bit bad_wr);
    int passes;
    int ba;
    passes = (n_commits > 0) ? 2 : 1;
    ba = $urandom_range(0, NO - 1);
    @(posedge clk); #1;
    bus.commit = 1'b0;
    bus.wr_en  = 1'b0;
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k < NO; k++) begin
        @(negedge clk);
        check("sweep_busy", bus.busy, 1);
        check("sweep_done", bus.done, 0);
        check("sweep_osel", bus.output_select, k);
        check("sweep_isel", bus.input_select, model[k]);
        check("sweep_wr_err", bus.wr_err, (bad_wr && p == 0 && k == 3) ? 1 : 0);
        bus.wr_en = 1'b0;
        if (bad_wr && p == 0 && k == 2) begin
          bus.wr_en   = 1'b1;
          bus.wr_addr = ba[AW-1:0];
          bus.wr_data = DW'((model[ba] + 1) % (NI + 2));
        end
        if (bad_wr && p == 0 && k == 3) bus.rd_addr = ba[AW-1:0];
        if (bad_wr && p == 0 && k == 5) check("busy_rd_data", bus.rd_data, model[ba]);
        bus.commit = (p == 0 && k >= 4 && k < 4 + n_commits) ? 1'b1 : 1'b0;
      end
      @(negedge clk);
      check("done_pulse", bus.done, 1);
      check("done_busy", bus.busy, 0);
      check("done_osel", bus.output_select, NO - 1);
      check("done_isel", bus.input_select, model[NO-1]);
    end
    bus.commit = 1'b0;
    park_out = NO - 1;
    park_in  = model[NO-1];
    @(negedge clk);
    check("idle_done", bus.done, 0);
    check("idle_busy", bus.busy, 0);
    check("idle_osel", bus.output_select, park_out);
    check("idle_isel", bus.input_select, park_in);
    #1;
    for (int k = 0; k < NO; k++) check("mux_latch", mux_sel[k], model[k]);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_addr = '0; bus.commit = 1'b0;
    for (int i = 0; i < NO; i++) model[i] = 0;
    park_in = 0; park_out = 0;

    // Reset state and full readback.
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_isel", bus.input_select, 0);
    check("rst_osel", bus.output_select, 0);
    check("rst_wr_err", bus.wr_err, 0);
    for (int a = 0; a < NO; a++) do_read(a);

    // Identity routing: output k carries input k.
    for (int a = 0; a < NO; a++) do_write(a, a + 2);
    bus.commit = 1'b1;
    run_sweep(0, 1'b0);
    in_vec = NI'($urandom);
    for (int k = 0; k < NO; k++) check("route_identity", route(mux_sel[k], in_vec), in_vec[k]);

    // Rejected writes leave the table intact.
    do_write(12, 3);
    do_write(3, 12);
    do_read(3);
    bus.commit = 1'b1;
    run_sweep(0, 1'b1);

    // Three commits during a sweep collapse into one re-sweep.
    bus.commit = 1'b1;
    run_sweep(3, 1'b0);

    // Write and commit in the same cycle: the sweep sees the new entry.
    bus.wr_en = 1'b1; bus.wr_addr = AW'(4); bus.wr_data = DW'(1);
    bus.commit = 1'b1;
    model[4] = 1;
    run_sweep(0, 1'b0);
    check("route_const_high", route(mux_sel[4], ~in_vec), 1);

    // Randomized rounds.
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 12; w++) do_write($urandom_range(0, 12), $urandom_range(0, NI + 3));
      for (int q = 0; q < 6; q++) do_read($urandom_range(0, (1 << AW) - 1));
      bus.commit = 1'b1;
      run_sweep($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a sweep with a re-sweep pending.
    bus.commit = 1'b1;
    @(posedge clk); #1;
    bus.commit = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.commit = (k == 1) ? 1'b1 : 1'b0;
    end
    check("pre_rst_osel", bus.output_select, 5);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < NO; i++) model[i] = 0;
    park_in = 0; park_out = 0;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_isel", bus.input_select, 0);
    check("abort_osel", bus.output_select, 0);
    check("abort_rd_data", bus.rd_data, 0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("abort_no_done", bus.done, 0);
      check("abort_idle", bus.busy, 0);
    end
    for (int a = 0; a < NO; a++) do_read(a);
    bus.commit = 1'b1;
    run_sweep(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
